// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus_fabric interconnect.
// Provides the FSM state encoding, the error cause codes reported on
// err_cause, the default read data for error completions, and a helper
// that sizes index/counter fields.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERR    = 2'b10
  } bus_state_t;

  localparam logic [1:0]  ERR_NONE         = 2'b00;
  localparam logic [1:0]  ERR_UNMAPPED     = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT      = 2'b10;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: cpu-side native memory port plus the broadcast slave bus.
//   mem_*  : picorv32 native memory port (valid/addr/wdata/wstrb in,
//            ready/rdata back to the cpu).
//   s_*    : one-hot select, broadcast address/data/strobes to the slaves,
//            per-slave ready and packed read data (slave 0 in the LSBs).
// Modports:
//   slave  : the fabric's view (it is the slave of the cpu request and
//            drives the slave-side select/broadcast signals).
//   master : the environment's view (cpu plus slave devices).
interface bus_fabric_if #(
  parameter int NUM_SLAVES = 3
) ();

  logic                       mem_valid;
  logic [31:0]                mem_addr;
  logic [31:0]                mem_wdata;
  logic [3:0]                 mem_wstrb;
  logic                       mem_ready;
  logic [31:0]                mem_rdata;

  logic [NUM_SLAVES-1:0]      s_sel;
  logic [31:0]                s_addr;
  logic [31:0]                s_wdata;
  logic [3:0]                 s_wstrb;
  logic [NUM_SLAVES-1:0]      s_ready;
  logic [NUM_SLAVES*32-1:0]   s_rdata;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output s_sel, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  s_sel, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/bus_addr_decoder.sv
// bus_addr_decoder: combinational address window match.
// Slave i hits when (i_addr & MASK_i) == BASE_i; when windows overlap the
// lowest index wins.
// Ports:
//   i_addr : address to decode.
//   o_hit  : at least one window matched.
//   o_idx  : index of the winning slave (0 when no hit).
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = {32'h80000100, 32'h80000000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = {32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFFE000},
  localparam int                       IDX_W      = bits_for(NUM_SLAVES)
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Priority encode: scan from the top so lower indices overwrite higher ones.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: single-master interconnect from the picorv32 native memory
// port to NUM_SLAVES memory-mapped slaves, with registered transaction
// tracking, an error completion for unmapped addresses, a ready-timeout
// watchdog and a sticky-first error capture that raises err_irq.
// Ports:
//   clk, reset : clock and asynchronous active-high reset.
//   bus        : cpu port and slave bus (bus_fabric_if.slave).
//   err_clr    : single-cycle clear of the captured error.
//   err_irq    : level interrupt while an error is captured.
//   err_addr   : address of the first captured error.
//   err_cause  : 01 unmapped, 10 timeout, 00 none.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                        NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASE = {32'h80000100, 32'h80000000, 32'h00000000},
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASK = {32'hFFFFFFF0, 32'hFFFFFFFF, 32'hFFFFE000},
  parameter int                        TIMEOUT    = 255,
  parameter logic [31:0]               ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  bus_fabric_if.slave bus,
  input  logic        err_clr,
  output logic        err_irq,
  output logic [31:0] err_addr,
  output logic [1:0]  err_cause
);

  localparam int                    IDX_W   = bits_for(NUM_SLAVES);
  localparam int                    CNT_W   = bits_for(TIMEOUT + 1);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

  bus_state_t            r_state;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_irq;
  logic [31:0]           r_err_addr;
  logic [1:0]            r_err_cause;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_slave_ready;
  logic [31:0]           w_sel_rdata;
  logic                  w_timeout;
  logic                  w_err_entry;
  logic [31:0]           w_err_addr;
  logic [1:0]            w_err_cause;

  bus_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_dec (
    .i_addr (bus.mem_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // Ready and read data of the currently selected slave (r_sel is one-hot).
  always_comb begin
    w_sel_rdata = 32'h00000000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) begin
        w_sel_rdata = w_sel_rdata | bus.s_rdata[i*32 +: 32];
      end
    end
    w_slave_ready = |(bus.s_ready & r_sel);
  end

  // Watchdog fires on the ACTIVE cycle whose increment would reach TIMEOUT.
  always_comb begin
    if (TIMEOUT != 0) begin
      w_timeout = ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));
    end else begin
      w_timeout = 1'b0;
    end
  end

  // Detect the edge that moves the FSM into ERR and what to capture there.
  always_comb begin
    w_err_entry = 1'b0;
    w_err_addr  = 32'h00000000;
    w_err_cause = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_valid && !w_hit) begin
          w_err_entry = 1'b1;
          w_err_addr  = bus.mem_addr;
          w_err_cause = ERR_UNMAPPED;
        end else begin
          w_err_entry = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (bus.mem_valid && !w_slave_ready && w_timeout) begin
          w_err_entry = 1'b1;
          w_err_addr  = r_addr;
          w_err_cause = ERR_TIMEOUT;
        end else begin
          w_err_entry = 1'b0;
        end
      end
      default: begin
        w_err_entry = 1'b0;
      end
    endcase
  end

  // Transaction FSM, broadcast registers, watchdog counter and error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_addr      <= 32'h00000000;
      r_wdata     <= 32'h00000000;
      r_wstrb     <= 4'b0000;
      r_cnt       <= '0;
      r_irq       <= 1'b0;
      r_err_addr  <= 32'h00000000;
      r_err_cause <= ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_valid) begin
            r_addr <= bus.mem_addr;
            if (w_hit) begin
              r_sel   <= SEL_ONE << w_idx;
              r_wdata <= bus.mem_wdata;
              r_wstrb <= bus.mem_wstrb;
              r_cnt   <= '0;
              r_state <= ST_ACTIVE;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end
        ST_ACTIVE: begin
          // Priority: cpu abort, then slave ready (ready beats the watchdog).
          if (!bus.mem_valid || w_slave_ready) begin
            r_sel   <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_sel   <= '0;
            r_state <= ST_ERR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_sel   <= '0;
          r_state <= ST_IDLE;
        end
      endcase

      // Sticky-first capture; a new error in the clear cycle is still taken.
      if (w_err_entry && (!r_irq || err_clr)) begin
        r_irq       <= 1'b1;
        r_err_addr  <= w_err_addr;
        r_err_cause <= w_err_cause;
      end else if (err_clr) begin
        r_irq       <= 1'b0;
        r_err_addr  <= 32'h00000000;
        r_err_cause <= ERR_NONE;
      end
    end
  end

  // Completion to the cpu is decoded from the state register.
  always_comb begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h00000000;
    case (r_state)
      ST_ACTIVE: begin
        bus.mem_ready = w_slave_ready;
        bus.mem_rdata = w_sel_rdata;
      end
      ST_ERR: begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = ERR_DATA;
      end
      default: begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h00000000;
      end
    endcase
  end

  assign bus.s_sel   = r_sel;
  assign bus.s_addr  = r_addr;
  assign bus.s_wdata = r_wdata;
  assign bus.s_wstrb = r_wstrb;
  assign err_irq     = r_irq;
  assign err_addr    = r_err_addr;
  assign err_cause   = r_err_cause;

endmodule
